// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the four-digit seven-segment display
// controller: controller state encoding, the hex-to-segment table and the
// blank (all-off) patterns for the active-low segment and anode buses.
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // nothing committed yet, display blank
        SCAN = 2'd1,  // showing the committed CPU value
        HALT = 2'd2   // showing the captured halt value, blinking
    } state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] BLANK_SEG = 7'h7F;
    localparam logic [3:0] BLANK_AN  = 4'hF;

endpackage

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Combinational nibble to seven-segment lookup.
//   nibble_i : hex digit to encode
//   seg_o    : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Four-digit multiplexed seven-segment display controller. CPU writes land in
// a shadow register and are committed only at frame end, so a frame is never
// torn. Once the core halts, the display switches (at a frame end) to the PC
// value captured at halt time and blinks it.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : one-cycle CPU store strobe, wr_data carries four hex nibbles
//   halt       : core halted (level), halt_val captured on its first cycle
//   seg        : registered active-low segments {g,f,e,d,c,b,a}
//   an         : registered active-low one-hot anodes
//   frame_done : registered one-cycle pulse after each frame end
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        halt,
    input  logic [15:0] halt_val,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       digit_q,    digit_d;
    logic [15:0]      shadow_q,   shadow_d;
    logic             pend_q,     pend_d;
    logic [15:0]      disp_q,     disp_d;
    logic             halt_lat_q, halt_lat_d;
    logic [15:0]      hval_q,     hval_d;
    state_e           state_q,    state_d;
    logic             vis_q,      vis_d;
    logic [FRM_W-1:0] fcnt_q,     fcnt_d;
    logic [6:0]       seg_q,      seg_d;
    logic [3:0]       an_q,       an_d;
    logic             frame_done_q, frame_done_d;

    logic             tc;
    logic             frame_end;
    logic             commit;
    logic             halt_now;
    logic [15:0]      src;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_o    (hex_seg)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        tc        = (cnt_q == CNT_LAST);
        frame_end = tc && (digit_q == 2'd3);
        // A write in the frame-end cycle itself is the newest value and commits.
        commit    = frame_end && (pend_q || wr_en);
        // A halt seen in the frame-end cycle already counts for this frame end.
        halt_now  = halt_lat_q || halt;

        cnt_d   = tc ? '0 : cnt_q + 1'b1;
        digit_d = tc ? digit_q + 2'd1 : digit_q;

        shadow_d = wr_en ? wr_data : shadow_q;
        pend_d   = pend_q;
        disp_d   = disp_q;
        if (commit) begin
            disp_d = wr_en ? wr_data : shadow_q;
            pend_d = 1'b0;
        end else if (wr_en) begin
            pend_d = 1'b1;
        end

        halt_lat_d = halt_now;
        hval_d     = (halt && !halt_lat_q) ? halt_val : hval_q;

        state_d = state_q;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (halt_now)    state_d = HALT;
                    else if (commit) state_d = SCAN;
                end
                SCAN:    if (halt_now) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end

        // Blink phase only runs while halted; entry restarts it visible.
        fcnt_d = fcnt_q;
        vis_d  = vis_q;
        if (frame_end) begin
            if (state_q == HALT) begin
                if (fcnt_q == FRM_LAST) begin
                    fcnt_d = '0;
                    vis_d  = ~vis_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end else if (state_d == HALT) begin
                fcnt_d = '0;
                vis_d  = 1'b1;
            end
        end

        src    = (state_q == HALT) ? hval_q : disp_q;
        nibble = src[{digit_q, 2'b00} +: 4];

        an_d  = BLANK_AN;
        seg_d = BLANK_SEG;
        if ((state_q == SCAN) || ((state_q == HALT) && vis_q)) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = hex_seg;
        end

        frame_done_d = frame_end;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            shadow_q     <= 16'h0000;
            pend_q       <= 1'b0;
            disp_q       <= 16'h0000;
            halt_lat_q   <= 1'b0;
            hval_q       <= 16'h0000;
            state_q      <= IDLE;
            vis_q        <= 1'b1;
            fcnt_q       <= '0;
            seg_q        <= BLANK_SEG;
            an_q         <= BLANK_AN;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            halt_lat_q   <= halt_lat_d;
            hval_q       <= hval_d;
            state_q      <= state_d;
            vis_q        <= vis_d;
            fcnt_q       <= fcnt_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Controller for the board's four-digit seven-segment display. It accepts 16-bit display writes from the CPU's memory-mapped I/O path and buffers them so the display never tears mid-frame. When the core halts, it switches the display to a halt value. It time-multiplexes the shared `seg` bus across the four anodes. It sits in `top_riscv_wrapper` between the core's MMIO decode and the `seg`/`an` pins.

## Interface

Parameters:
- `SCAN_DIV`, 100000: clock cycles per digit slot; the bench overrides it to 4.
- `BLINK_FRAMES`, 64: frames per blink phase in halt mode; the bench overrides it to 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  CPU store to the display register; one-cycle pulse.
- `wr_data`  in  16  value to display, four hex nibbles.
- `halt`  in  1  core halted, level.
- `halt_val`  in  16  value to show when halted (PC[15:0]).
- `seg`  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}; registered.
- `an`  out  4  anodes, active-low, one-hot-low; registered.
- `frame_done`  out  1  one-cycle pulse at every frame end.

## Operation

- Slot counter `cnt` runs 0..SCAN_DIV-1 and wraps. Its terminal count (TC) advances `digit` through 0→1→2→3→0.
- Frame end is TC while `digit`==3.
- Shadow register: `wr_en` loads `shadow`<=`wr_data` and sets `pend`. If several writes land in one frame, the last one wins.
- Commit: at frame end, if `pend` (or `wr_en` in that same cycle), `disp`<=newest value (`wr_data` if `wr_en`, otherwise `shadow`) and `pend` clears. `disp` never changes at any other time.
- Halt capture: on the first cycle `halt`=1, `halt_lat`<=1 and `hval`<=`halt_val`. Both are sticky until `rst`. Later changes on `halt_val` are ignored.
- States:
  - IDLE: blank, `an`=4'hF.
  - SCAN: shows `disp`.
  - HALT: shows `hval`, blinking.
- Transitions, all evaluated at frame end only:
  - IDLE→SCAN on commit.
  - IDLE/SCAN→HALT if `halt_lat`; HALT takes priority over a same-cycle commit.
  - HALT is left only by `rst`.
- Blink: frame counter 0..BLINK_FRAMES-1. In HALT, it toggles `vis` at each wrap. `vis`=1 on HALT entry. When `vis`=0, output is `an`=4'hF, `seg`=7'h7F.
- Digit mapping: `digit` d drives `an[d]`=0 and shows nibble `src[4d+3:4d]`.
- Hex encoding:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Writes continue to be accepted in HALT (shadow/commit keep running) but are not displayed.

## Timing

- Reset values: `an`=4'hF, `seg`=7'h7F, `frame_done`=0, `cnt`=0, `digit`=0, `shadow`=`disp`=`hval`=0, `pend`=`halt_lat`=0, state IDLE, `vis`=1, frame counter 0.
- `seg`/`an` are registered and reflect `digit`/state/`src` one cycle after they change.
- `frame_done` is registered and asserts the cycle after the frame-end TC.
- Frame length is 4·SCAN_DIV cycles.
- Write-to-display latency is 1 to 4·SCAN_DIV+1 cycles, depending on frame phase.
- `rst` mid-frame immediately forces all reset values; pending writes are lost.
- `halt` asserted in the frame-end cycle: captured that cycle, HALT entered at that same frame end.

## Structure

- Package `disp_pkg`:
  - state enum {IDLE, SCAN, HALT}
  - 16-entry hex→segment constant table
  - `BLANK_SEG`=7'h7F, `BLANK_AN`=4'hF
- Sub-module `hex7seg`: combinational nibble→segment lookup using the package table.
- All other logic is flat in `display_scan_ctrl`.

## Test plan

All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2, so one frame is 16 cycles.

1. Reset, no writes, 40 cycles → `an`=4'hF, `seg`=7'h7F throughout; `frame_done` pulses every 16 cycles.
2. Write 16'h1234 mid-frame → blank until frame end. The next frame shows `an`=E/`seg`=19, D/30, B/24, 7/79, each for 4 cycles.
3. Writes 16'hAAAA then 16'h5555 in the same frame → only 5555 is ever displayed. A write in the exact frame-end cycle commits at that frame end.
4. Display 16'h0008, then raise `halt` with `halt_val`=16'hBEEF and change `halt_val` afterwards → from the next frame, EF/BE digits are shown for 2 frames, then blank for 2 frames, repeating. Later `wr_en` has no visible effect.
5. Assert `rst` at `digit`=2 with `pend`=1 → outputs reset asynchronously. After release, the display stays blank until a new write commits.
